// File: rtl/monolith_pkg.sv
// Shared types and constants for the Monolith-31 permutation blocks.
package monolith_pkg;

   localparam int WORD_WIDTH          = 31;
   localparam int STATE_SIZE          = 16;
   localparam int MONOLITH_NUM_ROUNDS = 6;

   localparam logic [WORD_WIDTH-1:0] MERSENNE_31 = 31'h7FFF_FFFF;

   typedef logic [WORD_WIDTH-1:0] state_t [STATE_SIZE];

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } ctrl_state_e;

   // Round-constant table entry r (0-based), word i. The final entry is
   // all-zero. Values are generated from a fixed expression and reduced into
   // the field so the table is reproducible by any consumer.
   function automatic logic [WORD_WIDTH-1:0] rc_word(input int r, input int i,
                                                     input int num_rounds);
      int v;
      if (r < 0 || r >= num_rounds - 1) begin
         return '0;
      end
      v = (r + 1) * 65536 + i * 257 + 1;
      return WORD_WIDTH'(v % int'(MERSENNE_31));
   endfunction

endpackage

// File: rtl/monolith_round_constants.sv
// Combinational round-constant ROM. Index 0 (pre-round) gives all zeros,
// index k in 1..NUM_ROUNDS gives table entry k-1.
module monolith_round_constants
   import monolith_pkg::*;
#(
   parameter int  NUM_ROUNDS = MONOLITH_NUM_ROUNDS,
   localparam int IDX_W      = $clog2(NUM_ROUNDS + 1)
) (
   input  logic [IDX_W-1:0] i_idx,
   output state_t           o_constants
);

   // Constant-folded lookup: each word is a mux over the table entries.
   always_comb begin
      for (int i = 0; i < STATE_SIZE; i++) begin
         o_constants[i] = '0;
         for (int r = 0; r < NUM_ROUNDS; r++) begin
            if (int'(i_idx) == r + 1) begin
               o_constants[i] = rc_word(r, i, NUM_ROUNDS);
            end
         end
      end
   end

endmodule

// File: rtl/monolith_perm_ctrl.sv
// Sequencer driving one shared monolith_round instance through the pre-round
// and NUM_ROUNDS rounds of the Monolith permutation.
// Handshakes: a transfer happens on a clock edge where valid and ready are both
// high; a source holds valid and its data stable until that edge, and ready may
// not depend on valid combinationally.
module monolith_perm_ctrl
   import monolith_pkg::*;
#(
   parameter int  NUM_ROUNDS     = MONOLITH_NUM_ROUNDS,
   parameter int  TIMEOUT_CYCLES = 64,
   localparam int IDX_W          = $clog2(NUM_ROUNDS + 1),
   localparam int CNT_W          = $clog2(TIMEOUT_CYCLES)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  state_t           in_state,
   output logic             out_valid,
   input  logic             out_ready,
   output state_t           out_state,
   output logic             busy,
   output logic [IDX_W-1:0] round_idx,
   output logic             err_timeout,
   output logic             rnd_reset,
   output logic             rnd_pre_round,
   output state_t           rnd_state_in,
   output state_t           rnd_constants,
   input  state_t           rnd_state_out,
   input  logic             rnd_valid
);

   ctrl_state_e      r_state;
   ctrl_state_e      w_next_state;
   logic [IDX_W-1:0] r_round_idx;
   logic             r_err_timeout;
   state_t           r_state_reg;
   logic [CNT_W-1:0] r_wait_cnt;

   logic w_accept;
   logic w_round_ok;
   logic w_timeout;

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state decode and handshake/round-control outputs.
   always_comb begin
      w_next_state = r_state;
      w_accept     = 1'b0;
      w_round_ok   = 1'b0;
      w_timeout    = 1'b0;
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      busy         = 1'b1;
      rnd_reset    = 1'b1;
      unique case (r_state)
         ST_IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) begin
               w_accept     = 1'b1;
               w_next_state = ST_LOAD;
            end
         end
         ST_LOAD: begin
            w_next_state = ST_WAIT;
         end
         ST_WAIT: begin
            rnd_reset = 1'b0;
            // A valid on the final allowed cycle still counts as a result.
            if (rnd_valid) begin
               w_round_ok   = 1'b1;
               w_next_state = (r_round_idx == IDX_W'(NUM_ROUNDS)) ? ST_DONE : ST_LOAD;
            end else if (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               w_timeout    = 1'b1;
               w_next_state = ST_IDLE;
            end
         end
         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               w_next_state = ST_IDLE;
            end
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // Running state, round index, wait counter and sticky timeout flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state_reg   <= '{default: '0};
         r_round_idx   <= '0;
         r_err_timeout <= 1'b0;
         r_wait_cnt    <= '0;
      end else begin
         if (w_accept) begin
            r_state_reg   <= in_state;
            r_round_idx   <= '0;
            r_err_timeout <= 1'b0;
         end
         if (r_state == ST_LOAD) begin
            r_wait_cnt <= '0;
         end else if (r_state == ST_WAIT) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
         end
         if (w_round_ok) begin
            r_state_reg <= rnd_state_out;
            if (r_round_idx != IDX_W'(NUM_ROUNDS)) begin
               r_round_idx <= r_round_idx + 1'b1;
            end
         end
         if (w_timeout) begin
            r_err_timeout <= 1'b1;
         end
      end
   end

   // Result is presented only while DONE so idle/working cycles show zeros.
   always_comb begin
      for (int i = 0; i < STATE_SIZE; i++) begin
         out_state[i] = (r_state == ST_DONE) ? r_state_reg[i] : '0;
      end
   end

   assign round_idx     = r_round_idx;
   assign err_timeout   = r_err_timeout;
   assign rnd_pre_round = (r_round_idx == '0);
   assign rnd_state_in  = r_state_reg;

   monolith_round_constants #(
      .NUM_ROUNDS (NUM_ROUNDS)
   ) u_rc (
      .i_idx       (r_round_idx),
      .o_constants (rnd_constants)
   );

endmodule

// File: tb/tb_monolith_perm_ctrl.sv
// Bench for monolith_perm_ctrl with a stand-in round datapath of configurable
// latency and a whole-permutation reference model.
module tb_monolith_perm_ctrl;
   import monolith_pkg::*;

   localparam int NR = 6;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       in_valid = 1'b0;
   logic       out_ready = 1'b0;
   state_t     in_state;
   logic       in_ready, out_valid, busy, err_timeout;
   logic [2:0] round_idx;
   state_t     out_state;
   logic       rnd_reset, rnd_pre_round, rnd_valid;
   state_t     rnd_state_in, rnd_constants, rnd_state_out;

   int errors = 0;
   int checks = 0;

   monolith_perm_ctrl dut (
      .clk           (clk),
      .reset         (reset),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_state      (in_state),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_state     (out_state),
      .busy          (busy),
      .round_idx     (round_idx),
      .err_timeout   (err_timeout),
      .rnd_reset     (rnd_reset),
      .rnd_pre_round (rnd_pre_round),
      .rnd_state_in  (rnd_state_in),
      .rnd_constants (rnd_constants),
      .rnd_state_out (rnd_state_out),
      .rnd_valid     (rnd_valid)
   );

   // Clock
   always #5 clk = ~clk;

   // ---------------- stand-in round datapath ----------------
   int rm_w  = 4;
   bit rm_en = 1'b1;
   int rm_cnt;

   always @(posedge clk) begin
      if (rnd_reset) rm_cnt <= 0;
      else           rm_cnt <= rm_cnt + 1;
   end

   assign rnd_valid = rm_en && !rnd_reset && (rm_cnt >= rm_w - 1);

   always_comb begin
      for (int i = 0; i < STATE_SIZE; i++) begin
         rnd_state_out[i] = 31'(rnd_state_in[(i + 1) % STATE_SIZE] + rnd_constants[i]
                                + 31'((rnd_pre_round ? 7 : 1) * (i + 1)));
      end
   end

   // ---------------- reference model ----------------
   // Constants seen by round r (0 = pre-round, NR = last round, both zero).
   function automatic logic [30:0] exp_const(int r, int i);
      if (r == 0 || r == NR) return 31'd0;
      return 31'(r * 65536 + i * 257 + 1);
   endfunction

   function automatic state_t exp_const_state(int r);
      state_t c;
      for (int i = 0; i < STATE_SIZE; i++) c[i] = exp_const(r, i);
      return c;
   endfunction

   function automatic state_t model_round(state_t s, int r);
      state_t o;
      for (int i = 0; i < STATE_SIZE; i++)
         o[i] = 31'(s[(i + 1) % STATE_SIZE] + exp_const(r, i) + 31'((r == 0 ? 7 : 1) * (i + 1)));
      return o;
   endfunction

   state_t exp_chain [NR + 2];
   bit     have_exp = 1'b0;
   state_t pending;

   task automatic compute_chain(input state_t v);
      exp_chain[0] = v;
      for (int r = 0; r <= NR; r++) exp_chain[r + 1] = model_round(exp_chain[r], r);
   endtask

   // ---------------- check helpers ----------------
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_state(input string name, input state_t act, input state_t exp);
      int bad;
      bad = -1;
      checks++;
      for (int i = STATE_SIZE - 1; i >= 0; i--) if (act[i] !== exp[i]) bad = i;
      if (bad >= 0) begin
         errors++;
         $display("FAIL %s: word %0d got %0d expected %0d", name, bad, act[bad], exp[bad]);
      end
   endtask

   // ---------------- per-cycle compare ----------------
   bit cmp_en = 1'b0;

   always @(negedge clk) begin
      if (cmp_en && !reset) begin
         chk("in_ready_eq_not_busy", in_ready, !busy);
         chk("round_idx_range", round_idx <= 3'(NR), 1);
         if (!busy) begin
            chk("idle_out_valid", out_valid, 0);
            chk("idle_rnd_reset", rnd_reset, 1);
         end
         if (out_valid) begin
            chk("done_in_ready", in_ready, 0);
            chk("done_rnd_reset", rnd_reset, 1);
            if (have_exp) chk_state("out_state", out_state, exp_chain[NR + 1]);
         end else if (busy && have_exp && round_idx <= 3'(NR)) begin
            chk("rnd_pre_round", rnd_pre_round, round_idx == 0);
            chk_state("rnd_constants", rnd_constants, exp_const_state(int'(round_idx)));
            chk_state("rnd_state_in", rnd_state_in, exp_chain[round_idx]);
         end
      end
   end

   // ---------------- recorder ----------------
   int rec_idx[$], rec_pre[$], rec_c0[$], rec_c15[$], rec_s0[$], rec_s15[$];
   int wait_cycles = 0;
   bit saw_ov = 1'b0;

   always @(negedge clk) begin
      if (!reset) begin
         if (busy && !out_valid && rnd_reset) begin
            rec_idx.push_back(int'(round_idx));
            rec_pre.push_back(int'(rnd_pre_round));
            rec_c0.push_back(int'(rnd_constants[0]));
            rec_c15.push_back(int'(rnd_constants[15]));
            rec_s0.push_back(int'(rnd_state_in[0]));
            rec_s15.push_back(int'(rnd_state_in[15]));
         end
         if (busy && !rnd_reset) wait_cycles++;
         if (out_valid) saw_ov = 1'b1;
      end
   end

   task automatic clear_rec();
      rec_idx.delete(); rec_pre.delete(); rec_c0.delete();
      rec_c15.delete(); rec_s0.delete(); rec_s15.delete();
      wait_cycles = 0;
      saw_ov = 1'b0;
   endtask

   // ---------------- driver tasks ----------------
   task automatic offer(input state_t v);
      in_state = v;
      pending  = v;
      in_valid = 1'b1;
   endtask

   task automatic do_accept();
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (in_ready) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            compute_chain(pending);
            have_exp = 1'b1;
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("accept_bound", 0, 1);
   endtask

   task automatic wait_done(output int lat);
      bit found;
      found = 1'b0;
      lat = 0;
      for (int k = 0; k < 1000; k++) begin
         @(posedge clk);
         lat++;
         #1;
         if (out_valid) begin
            found = 1'b1;
            break;
         end
      end
      if (!found) chk("done_bound", 0, 1);
   endtask

   task automatic drain();
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("drain_in_ready", in_ready, 1);
      chk("drain_out_valid", out_valid, 0);
   endtask

   // ---------------- directed tests ----------------
   int exp_c0 [7] = '{0, 65537, 131073, 196609, 262145, 327681, 0};
   state_t zero_state;
   state_t v;
   int lat;
   bit found;

   initial begin
      zero_state = '{default: '0};
      in_state   = zero_state;

      // 1: reset held for three cycles
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rnd_reset", rnd_reset, 1);
      chk("rst_err_timeout", err_timeout, 0);
      chk("rst_round_idx", round_idx, 0);
      chk_state("rst_out_state", out_state, zero_state);
      reset  = 1'b0;
      cmp_en = 1'b1;

      // 2: input 0..15, round latency 4
      clear_rec();
      rm_w = 4;
      for (int i = 0; i < STATE_SIZE; i++) v[i] = 31'(i);
      offer(v);
      do_accept();
      wait_done(lat);
      chk("lat_w4", lat, 35);
      chk_state("perm_0_15", out_state, exp_chain[NR + 1]);
      chk("t2_loads", rec_idx.size(), 7);
      if (rec_s0.size() >= 2) begin
         chk("pre_round_word0", rec_s0[1], 8);
         chk("pre_round_word15", rec_s15[1], 112);
      end
      drain();

      // 3: round latency 2, constant sequence and load strobes
      clear_rec();
      rm_w = 2;
      for (int i = 0; i < STATE_SIZE; i++) v[i] = 31'(i * 1000 + 5);
      offer(v);
      do_accept();
      wait_done(lat);
      chk("lat_w2", lat, 21);
      chk("t3_loads", rec_idx.size(), 7);
      chk("t3_wait_cycles", wait_cycles, 14);
      for (int k = 0; k < rec_idx.size() && k < 7; k++) begin
         chk("t3_round_order", rec_idx[k], k);
         chk("t3_pre_round", rec_pre[k], (k == 0) ? 1 : 0);
         chk("t3_const_word0", rec_c0[k], exp_c0[k]);
      end
      if (rec_c15.size() >= 7) begin
         chk("rom4_word15", rec_c15[5], 331536);
         chk("rom5_word15", rec_c15[6], 0);
      end
      drain();

      // 4: back-pressure at DONE, second input waits for the drain
      rm_w = 1;
      for (int i = 0; i < STATE_SIZE; i++) v[i] = 31'(i * 3 + 1);
      offer(v);
      do_accept();
      wait_done(lat);
      chk("lat_w1", lat, 14);
      for (int i = 0; i < STATE_SIZE; i++) v[i] = 31'(i + 100);
      offer(v);
      for (int k = 0; k < 10; k++) begin
         @(posedge clk);
         #1;
         chk("hold_out_valid", out_valid, 1);
         chk("hold_in_ready", in_ready, 0);
         chk_state("hold_out_state", out_state, exp_chain[NR + 1]);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("t4_idle_after_drain", busy, 0);
      do_accept();
      wait_done(lat);
      chk("t4_second_lat", lat, 14);
      chk_state("t4_second_result", out_state, exp_chain[NR + 1]);
      drain();

      // 5: round never answers -> timeout after 64 WAIT cycles
      clear_rec();
      rm_en = 1'b0;
      for (int i = 0; i < STATE_SIZE; i++) v[i] = 31'(7 * i + 9);
      offer(v);
      do_accept();
      found = 1'b0;
      for (int k = 0; k < 200; k++) begin
         @(posedge clk);
         #1;
         if (!busy) begin
            found = 1'b1;
            break;
         end
      end
      chk("t5_returned_idle", found, 1);
      chk("t5_wait_cycles", wait_cycles, 64);
      chk("t5_err_timeout", err_timeout, 1);
      chk("t5_no_out_valid", saw_ov, 0);
      rm_en = 1'b1;
      rm_w  = 2;
      offer(v);
      do_accept();
      chk("t5_err_cleared", err_timeout, 0);
      wait_done(lat);
      chk_state("t5_retry_result", out_state, exp_chain[NR + 1]);
      drain();

      // 6: reset during WAIT of round 3
      rm_w = 3;
      for (int i = 0; i < STATE_SIZE; i++) v[i] = 31'(1000000 + i * 11);
      offer(v);
      do_accept();
      found = 1'b0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (round_idx == 3'd3 && busy && !rnd_reset) begin
            found = 1'b1;
            break;
         end
      end
      chk("t6_reached_round3", found, 1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("t6_in_ready", in_ready, 1);
      chk("t6_busy", busy, 0);
      chk("t6_out_valid", out_valid, 0);
      chk("t6_round_idx", round_idx, 0);
      chk("t6_err_timeout", err_timeout, 0);
      chk("t6_rnd_reset", rnd_reset, 1);
      chk_state("t6_out_state", out_state, zero_state);
      reset = 1'b0;
      rm_w  = 4;
      for (int i = 0; i < STATE_SIZE; i++) v[i] = 31'(31'h7FFF_0000 + i);
      offer(v);
      do_accept();
      wait_done(lat);
      chk("t6_lat", lat, 35);
      chk_state("t6_fresh_result", out_state, exp_chain[NR + 1]);
      drain();

      repeat (2) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Global time bound
   initial begin
      #500000;
      errors++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
